// File: rtl/chunk_cmd_arbiter_if.sv
// Chunk-command bus between N address loopers and the shared
// memory-request port. The master side is the requester/downstream
// environment; the slave side is the arbiter.
interface chunk_cmd_arbiter_if #(
    parameter int N     = 2,
    parameter int GBW   = 32,
    parameter int C_BW  = 6,
    parameter int V_BW1 = 5
);
    localparam int NBW = $clog2(N);

    // Upstream: one beat lane per requester
    logic [N-1:0]            i_cmd_rdy;
    logic [N-1:0]            i_cmd_ack;
    logic [N-1:0][1:0]       i_cmd_type;
    logic [N-1:0]            i_cmd_islast;
    logic [N-1:0][GBW-1:0]   i_cmd_addr;
    logic [N-1:0][C_BW-1:0]  i_cmd_addrofs;
    logic [N-1:0][V_BW1-1:0] i_cmd_len;

    // Downstream: single registered command port
    logic                    o_cmd_rdy;
    logic                    o_cmd_ack;
    logic [1:0]              o_cmd_type;
    logic                    o_cmd_islast;
    logic [GBW-1:0]          o_cmd_addr;
    logic [C_BW-1:0]         o_cmd_addrofs;
    logic [V_BW1-1:0]        o_cmd_len;
    logic [NBW-1:0]          o_cmd_src;

    modport master (
        output i_cmd_rdy, i_cmd_type, i_cmd_islast, i_cmd_addr,
               i_cmd_addrofs, i_cmd_len, o_cmd_ack,
        input  i_cmd_ack, o_cmd_rdy, o_cmd_type, o_cmd_islast,
               o_cmd_addr, o_cmd_addrofs, o_cmd_len, o_cmd_src
    );

    modport slave (
        input  i_cmd_rdy, i_cmd_type, i_cmd_islast, i_cmd_addr,
               i_cmd_addrofs, i_cmd_len, o_cmd_ack,
        output i_cmd_ack, o_cmd_rdy, o_cmd_type, o_cmd_islast,
               o_cmd_addr, o_cmd_addrofs, o_cmd_len, o_cmd_src
    );
endinterface

// File: rtl/chunk_cmd_arbiter.sv
// Round-robin burst arbiter: N chunk-address loopers share one
// registered downstream command port. A requester that gets a beat
// accepted keeps the port until its islast beat goes through, so the
// commands of one cache line stay contiguous.
module chunk_cmd_arbiter #(
    parameter int N     = 2,
    parameter int GBW   = 32,
    parameter int CSIZE = 64,
    parameter int VSIZE = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    chunk_cmd_arbiter_if.slave cmd
);
    localparam int C_BW  = $clog2(CSIZE);
    localparam int V_BW1 = $clog2(VSIZE + 1);
    localparam int NBW   = $clog2(N);
    localparam int NBW1  = NBW + 1;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t         state_reg, state_next;
    logic [NBW-1:0] rr_ptr_reg, rr_ptr_next;
    logic [NBW-1:0] lock_id_reg, lock_id_next;

    logic           slot_free;
    logic [NBW-1:0] rot_idx [N];
    logic           cand_found;
    logic [NBW-1:0] cand_id;
    logic           grant_valid;
    logic [NBW-1:0] grant_id;
    logic [N-1:0]   ack_vec;

    // Output slot may take a new beat when empty or draining this cycle
    assign slot_free = !cmd.o_cmd_rdy || cmd.o_cmd_ack;

    // Search order: rr_ptr, rr_ptr+1, ... modulo N (works for any N >= 2)
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [NBW:0] sum;
            logic [NBW:0] wrapped;
            assign sum         = {1'b0, rr_ptr_reg} + NBW1'(gi);
            assign wrapped     = (sum >= NBW1'(N)) ? sum - NBW1'(N) : sum;
            assign rot_idx[gi] = wrapped[NBW-1:0];
        end
    endgenerate

    // First ready requester in round-robin order; scanning downward lets
    // the nearest offset overwrite farther ones
    always_comb begin
        cand_found = 1'b0;
        cand_id    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (cmd.i_cmd_rdy[rot_idx[k]]) begin
                cand_found = 1'b1;
                cand_id    = rot_idx[k];
            end
        end
    end

    // Grant decision and next-state logic
    always_comb begin
        state_next   = state_reg;
        rr_ptr_next  = rr_ptr_reg;
        lock_id_next = lock_id_reg;
        grant_valid  = 1'b0;
        grant_id     = '0;
        ack_vec      = '0;

        if (i_rst && slot_free) begin
            case (state_reg)
                IDLE: begin
                    grant_valid = cand_found;
                    grant_id    = cand_id;
                end
                LOCK: begin
                    // Only the burst owner may proceed; a stalled owner idles the port
                    grant_valid = cmd.i_cmd_rdy[lock_id_reg];
                    grant_id    = lock_id_reg;
                end
                default: ;
            endcase
        end

        if (grant_valid) begin
            ack_vec[grant_id] = 1'b1;
            if (cmd.i_cmd_islast[grant_id]) begin
                state_next  = IDLE;
                rr_ptr_next = (grant_id == NBW'(N - 1)) ? '0 : grant_id + 1'b1;
            end else begin
                state_next   = LOCK;
                lock_id_next = grant_id;
            end
        end
    end

    assign cmd.i_cmd_ack = ack_vec;

    // Arbitration state register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= '0;
            lock_id_reg <= '0;
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            lock_id_reg <= lock_id_next;
        end
    end

    // Output slot: load the granted beat, otherwise hold or drain
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cmd.o_cmd_rdy     <= 1'b0;
            cmd.o_cmd_type    <= '0;
            cmd.o_cmd_islast  <= 1'b0;
            cmd.o_cmd_addr    <= '0;
            cmd.o_cmd_addrofs <= '0;
            cmd.o_cmd_len     <= '0;
            cmd.o_cmd_src     <= '0;
        end else if (grant_valid) begin
            cmd.o_cmd_rdy     <= 1'b1;
            cmd.o_cmd_type    <= cmd.i_cmd_type[grant_id];
            cmd.o_cmd_islast  <= cmd.i_cmd_islast[grant_id];
            cmd.o_cmd_addr    <= cmd.i_cmd_addr[grant_id];
            cmd.o_cmd_addrofs <= cmd.i_cmd_addrofs[grant_id];
            cmd.o_cmd_len     <= cmd.i_cmd_len[grant_id];
            cmd.o_cmd_src     <= grant_id;
        end else if (cmd.o_cmd_ack) begin
            cmd.o_cmd_rdy     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_chunk_cmd_arbiter.sv
// Randomized bench for chunk_cmd_arbiter (N=3). A burst-level reference
// model predicts which requester is acked each cycle and pushes the
// granted beat into a scoreboard queue; a monitor thread pops and
// compares whenever the DUT hands a beat downstream.
module tb_chunk_cmd_arbiter;
    localparam int N     = 3;
    localparam int GBW   = 32;
    localparam int CSIZE = 64;
    localparam int VSIZE = 16;
    localparam int C_BW  = 6;
    localparam int V_BW1 = 5;
    localparam int NBW   = 2;

    typedef struct packed {
        logic [1:0]       typ;
        logic             islast;
        logic [GBW-1:0]   addr;
        logic [C_BW-1:0]  ofs;
        logic [V_BW1-1:0] len;
        logic [NBW-1:0]   src;
    } beat_t;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    chunk_cmd_arbiter_if #(.N(N), .GBW(GBW), .C_BW(C_BW), .V_BW1(V_BW1)) bus ();

    chunk_cmd_arbiter #(.N(N), .GBW(GBW), .CSIZE(CSIZE), .VSIZE(VSIZE)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .cmd  (bus.slave)
    );

    int    vectors = 0;
    int    miscompares = 0;

    // Reference model: burst owner (-1 = none), round-robin start, slot fill
    int    owner, rr, cnt, gnt;
    beat_t exp_q[$];

    // Requester-side behaviour
    int    left[N];
    bit    has[N];
    beat_t cur[N];
    int    active_mask, p_rdy, p_ack, rst_cnt;

    task automatic apply_inputs();
        for (int k = 0; k < N; k++) begin
            bus.i_cmd_rdy[k]     = has[k];
            bus.i_cmd_type[k]    = cur[k].typ;
            bus.i_cmd_islast[k]  = cur[k].islast;
            bus.i_cmd_addr[k]    = cur[k].addr;
            bus.i_cmd_addrofs[k] = cur[k].ofs;
            bus.i_cmd_len[k]     = cur[k].len;
        end
    endtask

    task automatic gen_inputs();
        for (int k = 0; k < N; k++) begin
            if (!has[k] && (active_mask[k] || left[k] > 0) &&
                $urandom_range(0, 99) < p_rdy) begin
                if (left[k] == 0) left[k] = $urandom_range(1, 4);
                cur[k].typ    = 2'($urandom_range(0, 2));
                cur[k].islast = (left[k] == 1);
                cur[k].addr   = $urandom;
                cur[k].ofs    = C_BW'($urandom);
                cur[k].len    = V_BW1'($urandom_range(0, VSIZE));
                cur[k].src    = NBW'(k);
                has[k] = 1'b1;
            end
        end
        bus.o_cmd_ack = ($urandom_range(0, 99) < p_ack);
    endtask

    // One clock of stimulus + model; checks the ack vector and slot valid
    task automatic step();
        logic [N-1:0] exp_ack;
        @(negedge i_clk);
        gnt = -1;
        if (i_rst && (cnt == 0 || bus.o_cmd_ack)) begin
            if (owner >= 0) begin
                if (has[owner]) gnt = owner;
            end else begin
                for (int d = N - 1; d >= 0; d--)
                    if (has[(rr + d) % N]) gnt = (rr + d) % N;
            end
        end
        exp_ack = '0;
        if (gnt >= 0) exp_ack[gnt] = 1'b1;
        vectors++;
        if (bus.i_cmd_ack !== exp_ack) begin
            miscompares++;
            $display("FAIL ack @%0t: got %b want %b", $time, bus.i_cmd_ack, exp_ack);
        end
        vectors++;
        if (bus.o_cmd_rdy !== (cnt > 0)) begin
            miscompares++;
            $display("FAIL o_rdy @%0t: got %b want %b", $time, bus.o_cmd_rdy, cnt > 0);
        end

        @(posedge i_clk);
        if (!i_rst) begin
            owner = -1; rr = 0; cnt = 0;
            exp_q.delete();
        end else begin
            if (cnt > 0 && bus.o_cmd_ack) cnt--;
            if (gnt >= 0) begin
                exp_q.push_back(cur[gnt]);
                cnt++;
                if (cur[gnt].islast) begin
                    owner = -1;
                    rr = (gnt + 1) % N;
                end else begin
                    owner = gnt;
                end
                has[gnt] = 1'b0;
                left[gnt]--;
            end
        end

        #1;
        if (rst_cnt > 0) begin
            rst_cnt--;
            i_rst = 1'b0;
            for (int k = 0; k < N; k++) begin has[k] = 1'b0; left[k] = 0; end
        end else begin
            i_rst = 1'b1;
            gen_inputs();
        end
        apply_inputs();
    endtask

    task automatic run_phase(int mask, int pr, int pa, int cycles, int rst_at);
        active_mask = mask; p_rdy = pr; p_ack = pa;
        for (int c = 0; c < cycles; c++) begin
            if (c == rst_at) rst_cnt = 2;
            step();
        end
    endtask

    initial begin
        owner = -1; rr = 0; cnt = 0; rst_cnt = 0;
        active_mask = 0; p_rdy = 0; p_ack = 100;
        for (int k = 0; k < N; k++) begin
            has[k] = 1'b0; left[k] = 0; cur[k] = '0;
        end
        i_rst = 1'b0;
        bus.o_cmd_ack = 1'b1;
        apply_inputs();

        fork
            // Monitor: compare every beat handed downstream against the scoreboard
            forever begin
                @(negedge i_clk);
                if (bus.o_cmd_rdy === 1'b1 && bus.o_cmd_ack === 1'b1) begin
                    beat_t got, want;
                    got = {bus.o_cmd_type, bus.o_cmd_islast, bus.o_cmd_addr,
                           bus.o_cmd_addrofs, bus.o_cmd_len, bus.o_cmd_src};
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL beat @%0t: got %h want none", $time, got);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            miscompares++;
                            $display("FAIL beat @%0t: got %h want %h", $time, got, want);
                        end else begin
                            $display("beat src=%0d addr=%h last=%0d ok",
                                     got.src, got.addr, got.islast);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        vectors++;
        if ({bus.o_cmd_rdy, bus.o_cmd_type, bus.o_cmd_islast, bus.o_cmd_addr,
             bus.o_cmd_addrofs, bus.o_cmd_len, bus.o_cmd_src, bus.i_cmd_ack} !== '0) begin
            miscompares++;
            $display("FAIL reset: got rdy=%b src=%0d addr=%h ack=%b want all zero",
                     bus.o_cmd_rdy, bus.o_cmd_src, bus.o_cmd_addr, bus.i_cmd_ack);
        end
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        gen_inputs();
        apply_inputs();

        run_phase(3'b001, 80, 100, 300, -1);  // lone requester, full throughput
        run_phase(3'b111, 70, 100, 400, -1);  // three-way contention
        run_phase(3'b111, 50,  30, 400, -1);  // heavy downstream backpressure
        run_phase(3'b011, 90,  70, 400, 200); // two requesters, reset mid-traffic
        run_phase(3'b110, 60,  80, 300, -1);  // wrap through requester 2

        // Drain: finish open bursts and empty the output slot
        active_mask = 0; p_ack = 100; p_rdy = 100;
        begin
            int budget;
            bit busy;
            budget = 500;
            busy = 1'b1;
            while (busy && budget > 0) begin
                step();
                budget--;
                busy = (cnt > 0);
                for (int k = 0; k < N; k++) if (has[k] || left[k] > 0) busy = 1'b1;
            end
            vectors++;
            if (busy) begin
                miscompares++;
                $display("FAIL drain: got pending beats after 500 cycles want none");
            end
        end
        @(negedge i_clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: got %0d unmatched beats want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
